// File: rtl/second_countdown_timer.sv
// second_countdown_timer: loadable seconds countdown with prescaled ticks, abort, and a one-cycle done pulse
module second_countdown_timer #(
   parameter int CLKS_PER_SEC = 50000000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       beginCount,
   input  logic [9:0] counterSeconds,
   input  logic       abort,
   output logic       busy,
   output logic       done,
   output logic [9:0] remaining
);
   localparam int PW = CLKS_PER_SEC > 1 ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0] state;
   logic [PW-1:0] presc;
   logic tick;
   assign tick = presc == PW'(CLKS_PER_SEC - 1);
   assign busy = state == RUN;
   assign done = state == DONE;
   always_ff @(posedge Clock or negedge Reset)
      if (!Reset) begin
         state     <= IDLE;
         presc     <= '0;
         remaining <= '0;
      end else
         case (state)
            IDLE:
               if (beginCount && !abort) begin
                  remaining <= counterSeconds;
                  presc     <= '0;
                  state     <= counterSeconds == 10'd0 ? DONE : RUN;
               end
            RUN:
               // abort outranks a coincident final tick
               if (abort) begin
                  state     <= IDLE;
                  remaining <= '0;
                  presc     <= '0;
               end else if (tick) begin
                  presc <= '0;
                  if (remaining != 10'd0) remaining <= remaining - 10'd1;
                  if (remaining == 10'd1) state <= DONE;
               end else
                  presc <= presc + 1'b1;
            default: state <= IDLE;
         endcase
endmodule

// File: doc/second_countdown_timer.md
# second_countdown_timer

Loadable seconds countdown timer for the lab 2 controller datapath. It accepts a one-cycle `beginCount` strobe with a 10-bit duration in `counterSeconds` and divides the system clock into one-second ticks. It then counts the duration down to zero and reports completion with a single-cycle `done` pulse. It is the responder to the start/duration interface that the controller and `counter_tester` drive.

## Interface
- `CLKS_PER_SEC`, default 50000000: clock cycles per second tick. Must be ≥ 1. Benches override it with small values.

Ports:
- `Clock`, in, 1: system clock. All state changes on the rising edge.
- `Reset`, in, 1: one clock domain; reset is asynchronous and active-low.
- `beginCount`, in, 1: start strobe, sampled on rising edges.
- `counterSeconds`, in, 10: duration in seconds. Captured only on an accepted start.
- `abort`, in, 1: cancels a running count.
- `busy`, out, 1: high while counting (state RUN).
- `done`, out, 1: one-cycle completion pulse (state DONE).
- `remaining`, out, 10: seconds left, registered.

## Operation
- States:
  - IDLE: reset state. `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `done`=1, held one cycle only.
- Outputs are decoded directly from registered state. `remaining` is its own register.
- Reset asserted (`Reset`=0):
  - Immediately, with no clock edge: state=IDLE, `busy`=0, `done`=0, `remaining`=0, prescaler=0.
  - Applies from any state, including mid-RUN.
- IDLE, edge with `beginCount`=1 and `abort`=0:
  - `counterSeconds`≠0: `remaining`←`counterSeconds`, prescaler←0, go to RUN.
  - `counterSeconds`=0: `remaining`←0, go directly to DONE.
- IDLE, `abort`=1: wins over `beginCount`. The start is ignored and the block stays in IDLE.
- RUN, each edge:
  - Prescaler increments.
  - At prescaler = `CLKS_PER_SEC`−1: prescaler←0 and `remaining`←`remaining`−1.
  - If that decrement takes `remaining` from 1 to 0, go to DONE on the same edge.
- RUN, `beginCount`=1: ignored. No restart and no reload.
- RUN, `abort`=1: go to IDLE, `remaining`←0, prescaler←0. No `done` pulse. Abort beats a simultaneous final tick.
- DONE: unconditionally go to IDLE on the next edge. `beginCount` and `abort` are ignored in DONE.
- Width and arithmetic:
  - `remaining` never wraps below 0; the decrement occurs only when it is ≥ 1.
  - Maximum duration is 1023 s.
  - Prescaler width is ceil(log2(`CLKS_PER_SEC`)) with a minimum of 1 bit. `CLKS_PER_SEC`=1 means a decrement on every RUN cycle.

## Timing
- Start accepted at edge k with N≠0 and C=`CLKS_PER_SEC`:
  - After edge k: `busy`=1 and `remaining`=N.
  - Decrements occur at edges k+C, k+2C, …, k+N·C.
  - After edge k+N·C: `busy`=0, `done`=1, `remaining`=0.
  - After edge k+N·C+1: `done`=0 and the block is in IDLE.
  - The earliest next accepted start is edge k+N·C+2.
- Start accepted at edge k with N=0: `done`=1 for the cycle after edge k. `busy` never rises.
- `remaining` changes only on a load, a tick, an abort, or reset. It is stable between ticks.
- Latency from the start edge to `done` is exactly N·C cycles.

## Test plan
All scenarios use `CLKS_PER_SEC`=4 unless stated.
- Async reset: drive `Reset` 1→0 between edges during RUN with `remaining`=5. Required: `busy`, `done`, `remaining` all 0 before the next edge. After release, the block stays in IDLE until `beginCount`.
- Nominal run:
  - Stimulus: `counterSeconds`=7, `beginCount` high for one cycle.
  - Required: `busy` high for 28 cycles; `remaining` steps 7→6…→0 every 4 cycles.
  - `done` is high exactly one cycle, right after the 28th edge. `busy` is low during that cycle.
- Zero duration: `counterSeconds`=0 with a start. Required: `busy` stays 0; `done`=1 for exactly the next cycle.
- Ignored restart: during a 7 s run, assert `beginCount` with `counterSeconds`=3 at cycle 10. Required: `remaining` trajectory is unchanged and `done` still occurs at cycle 28.
- Abort:
  - Assert `abort` when `remaining`=5. Required: `busy`=0 and `remaining`=0 next cycle; no `done`.
  - A following start with 2 gives `done` 8 cycles later, with a fresh prescaler.
  - `abort`+`beginCount` together in IDLE: no start.
- Full width: `CLKS_PER_SEC`=1, `counterSeconds`=1023. Required: decrement every cycle with no wrap, and `done` exactly 1023 cycles after the start edge.
